// File: rtl/kan_operand_aligner_pkg.sv
// Shared definitions for the KAN operand aligner.
//   state_t   : controller states (LOAD=0, RUN=1, ERR=2)
//   op_width  : operand beat width {data, grid, scale}
//   clog2     : ceiling log2 for pointer/counter sizing
package kan_operand_aligner_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  function automatic int op_width(input int data_w, input int scale_w);
    return 2 * data_w + scale_w;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kan_operand_aligner_if.sv
// Stream bundle around the operand aligner.
//   s_axis_data_* : data samples in (tlast = final sample of the run)
//   s_axis_grid_* : grid vector in (tlast = last grid point)
//   s_axis_scle_* : scale vector in, same length as grid
//   m_axis_op_*   : combined operand beats out {data, grid, scale}
// Modports: slave = aligner view, master = environment view.
interface kan_operand_aligner_if
  import kan_operand_aligner_pkg::*;
#(
  parameter int DATA_WIDTH_DATA  = 16,
  parameter int DATA_WIDTH_SCALE = 16,
  parameter int OP_WIDTH         = op_width(DATA_WIDTH_DATA, DATA_WIDTH_SCALE)
);

  logic [DATA_WIDTH_DATA-1:0]  s_axis_data_tdata;
  logic                        s_axis_data_tvalid;
  logic                        s_axis_data_tready;
  logic                        s_axis_data_tlast;

  logic [DATA_WIDTH_DATA-1:0]  s_axis_grid_tdata;
  logic                        s_axis_grid_tvalid;
  logic                        s_axis_grid_tready;
  logic                        s_axis_grid_tlast;

  logic [DATA_WIDTH_SCALE-1:0] s_axis_scle_tdata;
  logic                        s_axis_scle_tvalid;
  logic                        s_axis_scle_tready;
  logic                        s_axis_scle_tlast;

  logic [OP_WIDTH-1:0]         m_axis_op_tdata;
  logic                        m_axis_op_tvalid;
  logic                        m_axis_op_tready;
  logic                        m_axis_op_tuser;
  logic                        m_axis_op_tlast;

  modport slave (
    input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    output s_axis_data_tready,
    input  s_axis_grid_tdata, s_axis_grid_tvalid, s_axis_grid_tlast,
    output s_axis_grid_tready,
    input  s_axis_scle_tdata, s_axis_scle_tvalid, s_axis_scle_tlast,
    output s_axis_scle_tready,
    output m_axis_op_tdata, m_axis_op_tvalid, m_axis_op_tuser, m_axis_op_tlast,
    input  m_axis_op_tready
  );

  modport master (
    output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    input  s_axis_data_tready,
    output s_axis_grid_tdata, s_axis_grid_tvalid, s_axis_grid_tlast,
    input  s_axis_grid_tready,
    output s_axis_scle_tdata, s_axis_scle_tvalid, s_axis_scle_tlast,
    input  s_axis_scle_tready,
    input  m_axis_op_tdata, m_axis_op_tvalid, m_axis_op_tuser, m_axis_op_tlast,
    output m_axis_op_tready
  );

endinterface

// File: rtl/kan_operand_aligner_vector_buffer.sv
// Operand vector buffer: GRID_DEPTH-entry register file of {grid, scale}.
//   clk, rst           : clock, synchronous active-high reset
//   wr_en/wr_ptr/wr_*  : synchronous write port
//   rd_ptr/rd_*        : asynchronous read port
module kan_operand_aligner_vector_buffer
  import kan_operand_aligner_pkg::*;
#(
  parameter int DATA_WIDTH_DATA  = 16,
  parameter int DATA_WIDTH_SCALE = 16,
  parameter int GRID_DEPTH       = 16,
  parameter int PTR_W            = clog2(GRID_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [PTR_W-1:0]            wr_ptr,
  input  logic [DATA_WIDTH_DATA-1:0]  wr_grid,
  input  logic [DATA_WIDTH_SCALE-1:0] wr_scle,
  input  logic [PTR_W-1:0]            rd_ptr,
  output logic [DATA_WIDTH_DATA-1:0]  rd_grid,
  output logic [DATA_WIDTH_SCALE-1:0] rd_scle
);

  logic [DATA_WIDTH_DATA-1:0]  grid_mem [GRID_DEPTH];
  logic [DATA_WIDTH_SCALE-1:0] scle_mem [GRID_DEPTH];

  // Cleared on reset so the read port never presents uninitialised contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GRID_DEPTH; i++) begin
        grid_mem[i] <= '0;
        scle_mem[i] <= '0;
      end
    end else if (wr_en) begin
      grid_mem[wr_ptr] <= wr_grid;
      scle_mem[wr_ptr] <= wr_scle;
    end
  end

  assign rd_grid = grid_mem[rd_ptr];
  assign rd_scle = scle_mem[rd_ptr];

endmodule

// File: rtl/kan_operand_aligner.sv
// KAN operand aligner: caches one grid/scale vector per run, then replays it
// for every data sample as {data, grid[i], scale[i]} operand beats.
//   clk, rst : clock, synchronous active-high reset
//   bus      : data/grid/scale stream inputs, operand stream output
//   busy     : high while replaying (RUN)
//   error    : sticky framing error (ERR), cleared only by rst
//   grid_len : number of grid points cached for the current run
module kan_operand_aligner
  import kan_operand_aligner_pkg::*;
#(
  parameter int DATA_WIDTH_DATA  = 16,
  parameter int DATA_WIDTH_SCALE = 16,
  parameter int GRID_DEPTH       = 16,
  parameter int OP_WIDTH         = op_width(DATA_WIDTH_DATA, DATA_WIDTH_SCALE)
) (
  input  logic                               clk,
  input  logic                               rst,
  kan_operand_aligner_if.slave               bus,
  output logic                               busy,
  output logic                               error,
  output logic [clog2(GRID_DEPTH+1)-1:0]     grid_len
);

  localparam int PTR_W = clog2(GRID_DEPTH);
  localparam int LEN_W = clog2(GRID_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(GRID_DEPTH - 1);

  state_t                      state;
  logic                        held;
  logic                        held_last;
  logic [DATA_WIDTH_DATA-1:0]  data_reg;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [DATA_WIDTH_DATA-1:0]  rd_grid;
  logic [DATA_WIDTH_SCALE-1:0] rd_scle;

  logic in_load, in_run;
  logic grid_hs, tlast_match, wr_en;
  logic last_pt, op_vld, op_hs, data_rdy, data_hs;

  assign in_load     = (state == ST_LOAD);
  assign in_run      = (state == ST_RUN);
  // Grid and scale are only ever consumed as a pair.
  assign grid_hs     = in_load & bus.s_axis_grid_tvalid & bus.s_axis_scle_tvalid;
  assign tlast_match = (bus.s_axis_grid_tlast == bus.s_axis_scle_tlast);
  // Misframed or overflowing beats go to ERR without touching the buffer.
  assign wr_en       = grid_hs & tlast_match & (bus.s_axis_grid_tlast | (wr_ptr != PTR_MAX));

  assign last_pt  = (LEN_W'(rd_ptr) == (grid_len - LEN_W'(1)));
  assign op_vld   = in_run & held;
  assign op_hs    = op_vld & bus.m_axis_op_tready;
  // Reload on the last grid point of a sample keeps the output bubble-free.
  assign data_rdy = in_run & (~held | (op_hs & last_pt & ~held_last));
  assign data_hs  = data_rdy & bus.s_axis_data_tvalid;

  assign bus.s_axis_grid_tready = grid_hs;
  assign bus.s_axis_scle_tready = grid_hs;
  assign bus.s_axis_data_tready = data_rdy;
  assign bus.m_axis_op_tvalid   = op_vld;
  assign bus.m_axis_op_tdata    = {data_reg, rd_grid, rd_scle};
  assign bus.m_axis_op_tuser    = op_vld & last_pt;
  assign bus.m_axis_op_tlast    = op_vld & last_pt & held_last;

  kan_operand_aligner_vector_buffer #(
    .DATA_WIDTH_DATA  (DATA_WIDTH_DATA),
    .DATA_WIDTH_SCALE (DATA_WIDTH_SCALE),
    .GRID_DEPTH       (GRID_DEPTH),
    .PTR_W            (PTR_W)
  ) u_operand_vector_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr),
    .wr_grid (bus.s_axis_grid_tdata),
    .wr_scle (bus.s_axis_scle_tdata),
    .rd_ptr  (rd_ptr),
    .rd_grid (rd_grid),
    .rd_scle (rd_scle)
  );

  always_ff @(posedge clk) begin
    if (data_hs) data_reg <= bus.s_axis_data_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      held      <= 1'b0;
      held_last <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      grid_len  <= '0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (grid_hs) begin
            if (!tlast_match) begin
              state <= ST_ERR;
              error <= 1'b1;
            end else if (bus.s_axis_grid_tlast) begin
              grid_len <= LEN_W'(wr_ptr) + LEN_W'(1);
              wr_ptr   <= '0;
              rd_ptr   <= '0;
              state    <= ST_RUN;
              busy     <= 1'b1;
            end else if (wr_ptr == PTR_MAX) begin
              state <= ST_ERR;
              error <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (data_hs) begin
            held      <= 1'b1;
            held_last <= bus.s_axis_data_tlast;
          end
          if (op_hs) begin
            if (last_pt) begin
              rd_ptr <= '0;
              if (held_last) begin
                // Run complete: a fresh grid is required for the next run.
                held   <= 1'b0;
                wr_ptr <= '0;
                state  <= ST_LOAD;
                busy   <= 1'b0;
              end else if (!data_hs) begin
                held <= 1'b0;
              end
            end else begin
              rd_ptr <= rd_ptr + PTR_W'(1);
            end
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_ERR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule
